// File: rtl/hazard_unit_if.sv
// Hazard-unit signal bundle: D-stage instruction attributes in, forward/stall/flush controls out.
interface hazard_unit_if;
  logic [4:0] RsD;
  logic [4:0] RtD;
  logic [4:0] WriteRegD;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       BranchD;
  logic       MulDivD;
  logic       MfHiLoD;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       ForwardAD;
  logic       ForwardBD;
  logic       StallF;
  logic       StallD;
  logic       FlushE;

  modport master (
    output RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, MulDivD, MfHiLoD,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE
  );

  modport slave (
    input  RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, MulDivD, MfHiLoD,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/mult-div stalls and E-stage bubbles.
// Define HAZARD_BRANCH_FWD_EN to resolve branches in D (ForwardAD/BD and branch stalls).
module hazard_unit #(
  parameter int unsigned MD_CYCLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  hazard_unit_if.slave hz
);

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES);

  logic [4:0] rs_e_r, rt_e_r, writereg_e_r, writereg_m_r, writereg_w_r;
  logic       regwrite_e_r, regwrite_m_r, regwrite_w_r;
  logic       memtoreg_e_r, memtoreg_m_r;
  logic [3:0] cnt_r;

  logic       lwstall_s, branchstall_s, mdstall_s, stall_s;
  logic [1:0] fwd_a_e_s, fwd_b_e_s;
  logic       fwd_a_d_s, fwd_b_d_s;

  function automatic logic reg_match(input logic [4:0] src, input logic wr_en,
                                     input logic [4:0] dst);
    return (src != 5'd0) && wr_en && (src == dst);
  endfunction

  // Shadow pipeline of destination/source tags; E takes a bubble whenever D is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_e_r       <= 5'd0;
      rt_e_r       <= 5'd0;
      writereg_e_r <= 5'd0;
      regwrite_e_r <= 1'b0;
      memtoreg_e_r <= 1'b0;
      writereg_m_r <= 5'd0;
      regwrite_m_r <= 1'b0;
      memtoreg_m_r <= 1'b0;
      writereg_w_r <= 5'd0;
      regwrite_w_r <= 1'b0;
    end else begin
      if (stall_s) begin
        rs_e_r       <= 5'd0;
        rt_e_r       <= 5'd0;
        writereg_e_r <= 5'd0;
        regwrite_e_r <= 1'b0;
        memtoreg_e_r <= 1'b0;
      end else begin
        rs_e_r       <= hz.RsD;
        rt_e_r       <= hz.RtD;
        writereg_e_r <= hz.WriteRegD;
        regwrite_e_r <= hz.RegWriteD;
        memtoreg_e_r <= hz.MemtoRegD;
      end
      writereg_m_r <= writereg_e_r;
      regwrite_m_r <= regwrite_e_r;
      memtoreg_m_r <= memtoreg_e_r;
      writereg_w_r <= writereg_m_r;
      regwrite_w_r <= regwrite_m_r;
    end
  end

  // Mult/div occupancy counter; a stalled MulDivD must not restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (hz.MulDivD && !stall_s) begin
      cnt_r <= MD_LOAD;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Forward selects and stall terms, all combinational from D inputs and shadow state.
  always_comb begin
    fwd_a_e_s = 2'b00;
    if (reg_match(rs_e_r, regwrite_m_r, writereg_m_r)) begin
      fwd_a_e_s = 2'b10;
    end else if (reg_match(rs_e_r, regwrite_w_r, writereg_w_r)) begin
      fwd_a_e_s = 2'b01;
    end else begin
      fwd_a_e_s = 2'b00;
    end

    fwd_b_e_s = 2'b00;
    if (reg_match(rt_e_r, regwrite_m_r, writereg_m_r)) begin
      fwd_b_e_s = 2'b10;
    end else if (reg_match(rt_e_r, regwrite_w_r, writereg_w_r)) begin
      fwd_b_e_s = 2'b01;
    end else begin
      fwd_b_e_s = 2'b00;
    end

    lwstall_s = memtoreg_e_r && (reg_match(hz.RsD, regwrite_e_r, writereg_e_r) ||
                                 reg_match(hz.RtD, regwrite_e_r, writereg_e_r));
    mdstall_s = (cnt_r != 4'd0) && (hz.MulDivD || hz.MfHiLoD);

`ifdef HAZARD_BRANCH_FWD_EN
    fwd_a_d_s     = reg_match(hz.RsD, regwrite_m_r, writereg_m_r);
    fwd_b_d_s     = reg_match(hz.RtD, regwrite_m_r, writereg_m_r);
    branchstall_s = hz.BranchD &&
                    (reg_match(hz.RsD, regwrite_e_r, writereg_e_r) ||
                     reg_match(hz.RtD, regwrite_e_r, writereg_e_r) ||
                     (memtoreg_m_r && (fwd_a_d_s || fwd_b_d_s)));
`else
    fwd_a_d_s     = 1'b0;
    fwd_b_d_s     = 1'b0;
    branchstall_s = 1'b0;
`endif

    stall_s = lwstall_s | branchstall_s | mdstall_s;
  end

`ifndef HAZARD_BRANCH_FWD_EN
  // Branches resolve in E here; these inputs are intentionally not consumed.
  logic unused_branch_s;
  assign unused_branch_s = hz.BranchD ^ memtoreg_m_r;
`endif

  assign hz.ForwardAE = fwd_a_e_s;
  assign hz.ForwardBE = fwd_b_e_s;
  assign hz.ForwardAD = fwd_a_d_s;
  assign hz.ForwardBD = fwd_b_d_s;
  assign hz.StallF    = stall_s;
  assign hz.StallD    = stall_s;
  assign hz.FlushE    = stall_s;

endmodule
